// File: rtl/time_and_date_pkg.sv
// rtl/time_and_date_pkg.sv - field layout, limits and calendar helpers for the BCD time/date word
// February leap handling in the clock is gated by TIME_AND_DATE_LEAP_YEAR_EN.
package time_and_date_pkg;

  localparam int TD_W      = 44;

  localparam int SEC_LSB   = 0;
  localparam int SEC_W     = 7;
  localparam int MIN_LSB   = 7;
  localparam int MIN_W     = 7;
  localparam int HOUR_LSB  = 14;
  localparam int HOUR_W    = 6;
  localparam int DAY_LSB   = 20;
  localparam int DAY_W     = 6;
  localparam int MON_LSB   = 26;
  localparam int MON_W     = 5;
  localparam int YEAR_LSB  = 31;
  localparam int YEAR_W    = 8;
  localparam int WDAY_LSB  = 39;
  localparam int WDAY_W    = 3;
  localparam int RSVD_LSB  = 42;
  localparam int RSVD_W    = 2;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 7'h59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 7'h59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 6'h23;
  localparam logic [MON_W-1:0]  MON_MAX  = 5'h12;
  localparam logic [YEAR_W-1:0] YEAR_MAX = 8'h99;

  localparam logic [TD_W-1:0] TD_RSVD_MASK = {2'b11, 42'd0};

  // 00:00:00, 01.01.00, Saturday
  localparam logic [TD_W-1:0] TD_RESET =
    {2'b00, 3'd6, 8'h00, 5'h01, 6'h01, 6'h00, 7'h00, 7'h00};

  // Year divisible by 4, evaluated directly on the two BCD digits.
  function automatic logic is_leap_year(input logic [7:0] year_bcd);
    logic [3:0] ones;
    ones = year_bcd[3:0];
    if (year_bcd[4])
      return (ones == 4'd2) || (ones == 4'd6);
    else
      return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
  endfunction

  // Unknown month codes fall back to 31 so the day field can still wrap.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] month_bcd,
                                                     input logic leap);
    case (month_bcd)
      5'h02:                      return leap ? 6'h29 : 6'h28;
      5'h04, 5'h06, 5'h09, 5'h11: return 6'h30;
      default:                    return 6'h31;
    endcase
  endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// rtl/bcd_wrap_counter.sv - two-digit BCD field incrementer with wrap to min at or above max
module bcd_wrap_counter #(
  parameter int TENS_W = 4
) (
  input  logic              inc,
  input  logic [TENS_W+3:0] val,
  input  logic [TENS_W+3:0] max,
  input  logic [TENS_W+3:0] min,
  output logic [TENS_W+3:0] next_val,
  output logic              carry
);

  always_comb begin
    carry    = inc && (val >= max);
    next_val = val;
    if (carry) begin
      next_val = min;
    end else if (inc) begin
      // ">= 9" rather than "== 9" so an illegal ones digit recovers too
      if (val[3:0] >= 4'd9)
        next_val = {val[TENS_W+3:4] + 1'b1, 4'd0};
      else
        next_val = {val[TENS_W+3:4], val[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/time_and_date_clock.sv
// rtl/time_and_date_clock.sv - BCD real-time clock/calendar register, one second per 1 Hz enable
// Define TIME_AND_DATE_LEAP_YEAR_EN to give February 29 days in leap years.
module time_and_date_clock
  import time_and_date_pkg::*;
(
  input  logic            clk,
  input  logic            nReset,
  input  logic            clkEn1Hz,
  input  logic            setTimeAndDate_in,
  input  logic [TD_W-1:0] timeAndDate_In,
  output logic [TD_W-1:0] timeAndDate_Out
);

  logic [TD_W-1:0]   td_q, td_d;

  logic [SEC_W-1:0]  sec_next;
  logic [MIN_W-1:0]  min_next;
  logic [HOUR_W-1:0] hour_next;
  logic [DAY_W-1:0]  day_next;
  logic [MON_W-1:0]  mon_next;
  logic [YEAR_W-1:0] year_next;
  logic [WDAY_W-1:0] wday_q, wday_next;
  logic              sec_carry, min_carry, hour_carry, day_carry, mon_carry, year_carry;
  logic              leap;
  logic [DAY_W-1:0]  day_max;

  bcd_wrap_counter #(.TENS_W(3)) u_sec (
    .inc(clkEn1Hz), .val(td_q[SEC_LSB +: SEC_W]), .max(SEC_MAX), .min(7'h00),
    .next_val(sec_next), .carry(sec_carry)
  );

  bcd_wrap_counter #(.TENS_W(3)) u_min (
    .inc(sec_carry), .val(td_q[MIN_LSB +: MIN_W]), .max(MIN_MAX), .min(7'h00),
    .next_val(min_next), .carry(min_carry)
  );

  bcd_wrap_counter #(.TENS_W(2)) u_hour (
    .inc(min_carry), .val(td_q[HOUR_LSB +: HOUR_W]), .max(HOUR_MAX), .min(6'h00),
    .next_val(hour_next), .carry(hour_carry)
  );

`ifdef TIME_AND_DATE_LEAP_YEAR_EN
  assign leap = is_leap_year(td_q[YEAR_LSB +: YEAR_W]);
`else
  assign leap = 1'b0;
`endif

  assign day_max = days_in_month(td_q[MON_LSB +: MON_W], leap);

  bcd_wrap_counter #(.TENS_W(2)) u_day (
    .inc(hour_carry), .val(td_q[DAY_LSB +: DAY_W]), .max(day_max), .min(6'h01),
    .next_val(day_next), .carry(day_carry)
  );

  bcd_wrap_counter #(.TENS_W(1)) u_mon (
    .inc(day_carry), .val(td_q[MON_LSB +: MON_W]), .max(MON_MAX), .min(5'h01),
    .next_val(mon_next), .carry(mon_carry)
  );

  // Year rolls 99 -> 00; nothing above it consumes the carry.
  bcd_wrap_counter #(.TENS_W(4)) u_year (
    .inc(mon_carry), .val(td_q[YEAR_LSB +: YEAR_W]), .max(YEAR_MAX), .min(8'h00),
    .next_val(year_next), .carry(year_carry)
  );

  assign wday_q = td_q[WDAY_LSB +: WDAY_W];

  always_comb begin
    wday_next = wday_q;
    if (hour_carry) begin
      if ((wday_q >= 3'd7) || (wday_q == 3'd0))
        wday_next = 3'd1;
      else
        wday_next = wday_q + 3'd1;
    end
  end

  always_comb begin
    td_d = td_q;
    if (setTimeAndDate_in) begin
      td_d = timeAndDate_In & ~TD_RSVD_MASK;
    end else if (clkEn1Hz) begin
      td_d = {{RSVD_W{1'b0}}, wday_next, year_next, mon_next, day_next,
              hour_next, min_next, sec_next};
    end
  end

  always_ff @(posedge clk) begin
    if (nReset)
      td_q <= TD_RESET;
    else
      td_q <= td_d;
  end

  assign timeAndDate_Out = td_q;

endmodule

// File: tb/tb_time_and_date_clock.sv
// tb/tb_time_and_date_clock.sv - randomized and directed checks of time_and_date_clock against a calendar model
module tb_time_and_date_clock;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        clkEn1Hz = 1'b0;
  logic        setTimeAndDate_in = 1'b0;
  logic [43:0] timeAndDate_In = '0;
  logic [43:0] timeAndDate_Out;

  int checks = 0;
  int errors = 0;

  // calendar model state in plain integers
  int m_s, m_mi, m_h, m_d, m_mo, m_y, m_w;
  // pending load value
  int l_s, l_mi, l_h, l_d, l_mo, l_y, l_w;

  time_and_date_clock dut (
    .clk(clk),
    .nReset(nReset),
    .clkEn1Hz(clkEn1Hz),
    .setTimeAndDate_in(setTimeAndDate_in),
    .timeAndDate_In(timeAndDate_In),
    .timeAndDate_Out(timeAndDate_Out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [43:0] got, input logic [43:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [43:0] pack(int s, int mi, int h, int d, int mo, int y, int w);
    longint r;
    r = longint'(s % 10)           | (longint'(s / 10) << 4)  |
        (longint'(mi % 10) << 7)   | (longint'(mi / 10) << 11) |
        (longint'(h % 10) << 14)   | (longint'(h / 10) << 18)  |
        (longint'(d % 10) << 20)   | (longint'(d / 10) << 24)  |
        (longint'(mo % 10) << 26)  | (longint'(mo / 10) << 30) |
        (longint'(y % 10) << 31)   | (longint'(y / 10) << 35)  |
        (longint'(w) << 39);
    return r[43:0];
  endfunction

  function automatic int dim(int mo, int y);
    bit leap;
`ifdef TIME_AND_DATE_LEAP_YEAR_EN
    leap = (y % 4 == 0);
`else
    leap = 1'b0;
`endif
    case (mo)
      2:            return leap ? 29 : 28;
      4, 6, 9, 11:  return 30;
      default:      return 31;
    endcase
  endfunction

  task automatic model_reset();
    m_s = 0; m_mi = 0; m_h = 0; m_d = 1; m_mo = 1; m_y = 0; m_w = 6;
  endtask

  task automatic model_tick();
    if (m_s < 59) begin m_s++; return; end
    m_s = 0;
    if (m_mi < 59) begin m_mi++; return; end
    m_mi = 0;
    if (m_h < 23) begin m_h++; return; end
    m_h = 0;
    m_w = (m_w >= 7 || m_w == 0) ? 1 : m_w + 1;
    if (m_d < dim(m_mo, m_y)) begin m_d++; return; end
    m_d = 1;
    if (m_mo < 12) begin m_mo++; return; end
    m_mo = 1;
    m_y = (m_y >= 99) ? 0 : m_y + 1;
  endtask

  task automatic set_load(int s, int mi, int h, int d, int mo, int y, int w);
    l_s = s; l_mi = mi; l_h = h; l_d = d; l_mo = mo; l_y = y; l_w = w;
  endtask

  // One clock: drive on the falling edge, compare 1 ns after the rising edge.
  task automatic cycle(input string tag, input bit rst, input bit set, input bit en);
    logic [43:0] drv;
    drv = pack(l_s, l_mi, l_h, l_d, l_mo, l_y, l_w);
    drv[43:42] = 2'($urandom_range(0, 3));
    @(negedge clk);
    nReset = rst;
    setTimeAndDate_in = set;
    clkEn1Hz = en;
    timeAndDate_In = drv;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else if (set) begin
      m_s = l_s; m_mi = l_mi; m_h = l_h; m_d = l_d; m_mo = l_mo; m_y = l_y; m_w = l_w;
    end else if (en) model_tick();
    check(tag, timeAndDate_Out, pack(m_s, m_mi, m_h, m_d, m_mo, m_y, m_w));
  endtask

  task automatic rand_load();
    int mo, y;
    mo = $urandom_range(1, 12);
    y  = $urandom_range(0, 99);
    set_load($urandom_range(50, 59), $urandom_range(57, 59), $urandom_range(21, 23),
             dim(mo, y) - $urandom_range(0, 1), mo, y, $urandom_range(1, 7));
  endtask

  initial begin
    set_load(0, 0, 0, 1, 1, 0, 6);
    cycle("reset", 1'b1, 1'b0, 1'b0);
    check("reset_const", timeAndDate_Out, 44'h300_0410_0000);

    set_load(59, 59, 23, 31, 12, 99, 5);
    cycle("load_new_year", 1'b0, 1'b1, 1'b0);
    cycle("tick_new_year", 1'b0, 1'b0, 1'b1);
    check("new_year_const", timeAndDate_Out, 44'h300_0410_0000);

    set_load(59, 59, 23, 28, 2, 24, 3);
    cycle("load_feb24", 1'b0, 1'b1, 1'b0);
    cycle("tick_feb24", 1'b0, 1'b0, 1'b1);
`ifdef TIME_AND_DATE_LEAP_YEAR_EN
    check("feb24_const", timeAndDate_Out, pack(0, 0, 0, 29, 2, 24, 4));
`else
    check("feb24_const", timeAndDate_Out, pack(0, 0, 0, 1, 3, 24, 4));
`endif

    set_load(59, 59, 23, 28, 2, 23, 2);
    cycle("load_feb23", 1'b0, 1'b1, 1'b0);
    cycle("tick_feb23", 1'b0, 1'b0, 1'b1);
    check("feb23_const", timeAndDate_Out, pack(0, 0, 0, 1, 3, 23, 3));

    set_load(59, 59, 23, 30, 4, 23, 7);
    cycle("load_apr23", 1'b0, 1'b1, 1'b0);
    cycle("tick_apr23", 1'b0, 1'b0, 1'b1);
    check("apr23_const", timeAndDate_Out, pack(0, 0, 0, 1, 5, 23, 1));

    set_load(59, 59, 23, 10, 6, 21, 0);
    cycle("load_wday0", 1'b0, 1'b1, 1'b0);
    cycle("tick_wday0", 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) cycle("hold", 1'b0, 1'b0, 1'b0);

    set_load(0, 0, 12, 15, 6, 21, 2);
    cycle("set_and_tick", 1'b0, 1'b1, 1'b1);
    check("set_and_tick_const", timeAndDate_Out, pack(0, 0, 12, 15, 6, 21, 2));

    cycle("reset_during_tick", 1'b1, 1'b0, 1'b1);
    check("reset_tick_const", timeAndDate_Out, 44'h300_0410_0000);

    for (int n = 0; n < 30; n++) begin
      rand_load();
      cycle("rand_load", 1'b0, 1'b1, $urandom_range(0, 1) == 1);
      for (int k = 0, len = $urandom_range(5, 80); k < len; k++) begin
        bit set;
        set = ($urandom_range(0, 31) == 0);
        if (set) rand_load();
        cycle("rand_run", 1'b0, set, $urandom_range(0, 3) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_and_date_clock.md
Name: time_and_date_clock

Overview:
Real-time clock/calendar register holding BCD time (hh:mm:ss), date (DD.MM.YY) and weekday in one 44-bit word. It advances one second per clock cycle in which the 1 Hz enable is high, and can be loaded synchronously from an external word. It sits between the 1 Hz enable divider and the display/set-up logic of the clock design.

Parameters:
None. Field layout and limits are fixed constants in the shared package.

Ports:
clk  input  1  system clock; all logic acts on its rising edge
nReset  input  1  reset; one clock; reset is synchronous and active-high
clkEn1Hz  input  1  single-cycle 1 Hz tick enable
setTimeAndDate_in  input  1  load strobe; level-sensitive, loads every cycle it is high
timeAndDate_In  input  44  value to load; same layout as the output
timeAndDate_Out  output  44  current time/date word, driven directly from the state register

Behaviour:
- Word layout, all fields BCD:
  - [3:0] second ones; [6:4] second tens
  - [10:7] minute ones; [13:11] minute tens
  - [17:14] hour ones; [19:18] hour tens
  - [23:20] day ones; [25:24] day tens
  - [29:26] month ones; [30] month tens
  - [34:31] year ones; [38:35] year tens (years 2000-2099)
  - [41:39] weekday, 1=Mon to 7=Sun
  - [43:42] reserved; always output 0
- Priority per rising edge: nReset > setTimeAndDate_in > clkEn1Hz > hold.
- Reset value: 00:00:00, 01.01.00, weekday 6 (2000-01-01 was a Saturday), reserved 00.
- Load: state <= timeAndDate_In with [43:42] forced to 0. The value is taken verbatim with no validation. Visible on the output the cycle after the edge.
- Tick: the whole cascade updates in the same edge, so the output shows the new value one cycle after the enable.
- Simultaneous load and tick: only the load takes effect; that tick is dropped.
- Cascade rule: a digit or field increments only when all lower fields wrap.
  - Any field at or above its maximum wraps, so corrupt loaded values self-recover.
  - Seconds 59->00 carries into minutes.
  - Minutes 59->00 carries into hours.
  - Hours 23->00 carries into day and weekday.
  - Weekday 7->1; an out-of-range weekday (0) becomes 1.
  - Day wraps to 01 when day >= days-in-month, then month increments.
  - Month wraps to 01 when month >= 12, then year increments.
  - Year 99->00.
- Days-in-month: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; February per the optional feature.
- The BCD ones digit wraps 9->0 with a carry into its tens digit.
- No combinational path from inputs to the output.

Optional Feature:
TIME_AND_DATE_LEAP_YEAR_EN
- Defined: February has 29 days when the year is divisible by 4 (BCD test: tens even with ones in {0,4,8}, or tens odd with ones in {2,6}); otherwise 28.
- Undefined: February always has 28 days and the leap logic is not compiled.

Decomposition:
- Package time_and_date_pkg holds:
  - bit-position/slice constants for every field
  - the 44-bit reset constant
  - a days_in_month function (BCD month, leap flag) returning a BCD day
  - a leap-year function
- One natural sub-module: bcd_wrap_counter, a two-digit BCD counter with inputs inc, max, min and output carry. It is instantiated for seconds, minutes, hours, day, month and year.
- Weekday logic stays inline.

Test Plan:
- Reset: assert nReset for 1 cycle -> output 00:00:00, 01.01.00, weekday 6.
- Load 23:59:59, 31.12.99, weekday 5, then one cycle with clkEn1Hz high -> 00:00:00, 01.01.00, weekday 6.
- Load 23:59:59, 28.02.24, then tick -> 29.02.24 with the macro defined, 01.03.24 without it.
- Load 23:59:59, 28.02.23, then tick -> 01.03.23.
- Load 23:59:59, 30.04.23, then tick -> 01.05.23.
- Hold and priority checks:
  - clkEn1Hz low for 10 cycles -> output unchanged.
  - Set and tick in the same cycle with input 12:00:00 -> output exactly 12:00:00.
  - nReset asserted during a tick -> reset value.
